// File: rtl/seq_divider_8bit.sv
// Sequential restoring radix-2 unsigned divider: one quotient bit per clock,
// start/done handshake, divide-by-zero returns all-ones quotient and the dividend.
module seq_divider_8bit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] ia,
    input  logic [WIDTH-1:0] ib,
    output logic             ready,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] ot_q,
    output logic [WIDTH-1:0] ot_r
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] divisor_nxt;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH-1:0] q_sh_nxt;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] r_sh_nxt;
    logic [CW-1:0]    count;
    logic [CW-1:0]    count_nxt;
    logic [WIDTH-1:0] ot_q_nxt;
    logic [WIDTH-1:0] ot_r_nxt;
    logic             dz_nxt;
    logic             done_nxt;
    logic             ready_nxt;

    logic [WIDTH:0]   trial;
    logic [WIDTH+1:0] diff;
    logic             borrow;

    // Trial subtraction of the divisor from the shifted partial remainder.
    always_comb begin
        trial  = {r_sh, q_sh[WIDTH-1]};
        diff   = {1'b0, trial} - {2'b00, divisor};
        borrow = diff[WIDTH+1];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nxt = (ib == '0) ? S_DONE : S_RUN;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (count == CW'(1)) begin
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath and output next values; everything holds unless loaded.
    always_comb begin
        divisor_nxt = divisor;
        q_sh_nxt    = q_sh;
        r_sh_nxt    = r_sh;
        count_nxt   = count;
        ot_q_nxt    = ot_q;
        ot_r_nxt    = ot_r;
        dz_nxt      = dz;
        done_nxt    = (state_nxt == S_DONE);
        ready_nxt   = (state_nxt != S_RUN);

        if (state != S_RUN && start) begin
            if (ib == '0) begin
                ot_q_nxt = '1;
                ot_r_nxt = ia;
                dz_nxt   = 1'b1;
            end else begin
                divisor_nxt = ib;
                q_sh_nxt    = ia;
                r_sh_nxt    = '0;
                count_nxt   = CW'(WIDTH);
                dz_nxt      = 1'b0;
            end
        end else if (state == S_RUN) begin
            r_sh_nxt  = borrow ? WIDTH'(trial) : WIDTH'(diff);
            q_sh_nxt  = {q_sh[WIDTH-2:0], ~borrow};
            count_nxt = count - CW'(1);
            if (count == CW'(1)) begin
                ot_q_nxt = q_sh_nxt;
                ot_r_nxt = r_sh_nxt;
                dz_nxt   = 1'b0;
            end
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            divisor <= '0;
            q_sh    <= '0;
            r_sh    <= '0;
            count   <= '0;
            ot_q    <= '0;
            ot_r    <= '0;
            dz      <= 1'b0;
            done    <= 1'b0;
            ready   <= 1'b1;
        end else begin
            divisor <= divisor_nxt;
            q_sh    <= q_sh_nxt;
            r_sh    <= r_sh_nxt;
            count   <= count_nxt;
            ot_q    <= ot_q_nxt;
            ot_r    <= ot_r_nxt;
            dz      <= dz_nxt;
            done    <= done_nxt;
            ready   <= ready_nxt;
        end
    end

endmodule

// File: tb/tb_seq_divider_8bit.sv
// Self-checking bench for seq_divider_8bit: directed vector table, hand-built
// multi-cycle sequences and a randomized sweep against an arithmetic model.
module tb_seq_divider_8bit;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] ia;
    logic [7:0] ib;
    logic       ready;
    logic       done;
    logic       dz;
    logic [7:0] ot_q;
    logic [7:0] ot_r;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int a;
        int b;
        int eq;
        int er;
        int ez;
    } vec_t;

    seq_divider_8bit #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .ia    (ia),
        .ib    (ib),
        .ready (ready),
        .done  (done),
        .dz    (dz),
        .ot_q  (ot_q),
        .ot_r  (ot_r)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one start, then wait (bounded) for done; reports latency in edges
    // after the start edge, ready-high cycles while busy, and output changes while busy.
    task automatic run_op(input int a, input int b,
                          output int q, output int r, output int z,
                          output int lat, output int ready_err, output int hold_err);
        logic [7:0] pq;
        logic [7:0] pr;
        pq = ot_q;
        pr = ot_r;
        ia = 8'(a);
        ib = 8'(b);
        start = 1'b1;
        tick();
        start = 1'b0;
        ia = 8'($urandom);
        ib = 8'($urandom);
        lat = 0;
        ready_err = 0;
        hold_err = 0;
        while (!done && lat < 30) begin
            if (ready) ready_err++;
            if (ot_q != pq || ot_r != pr) hold_err++;
            tick();
            lat++;
        end
        q = int'(ot_q);
        r = int'(ot_r);
        z = int'(dz);
    endtask

    task automatic do_vec(input string tag, input int a, input int b,
                          input int eq, input int er, input int ez);
        int q, r, z, lat, rerr, herr;
        run_op(a, b, q, r, z, lat, rerr, herr);
        chk({tag, " quotient"}, q, eq);
        chk({tag, " remainder"}, r, er);
        chk({tag, " dz"}, z, ez);
        chk({tag, " latency"}, lat, (b == 0) ? 0 : 8);
        chk({tag, " ready low while busy"}, rerr, 0);
        chk({tag, " result hold while busy"}, herr, 0);
    endtask

    initial begin
        vec_t vecs[9];
        int   lat;
        int   seen;

        vecs[0] = '{200, 7, 28, 4, 0};
        vecs[1] = '{255, 1, 255, 0, 0};
        vecs[2] = '{5, 9, 0, 5, 0};
        vecs[3] = '{255, 255, 1, 0, 0};
        vecs[4] = '{100, 0, 255, 100, 1};
        vecs[5] = '{200, 7, 28, 4, 0};
        vecs[6] = '{0, 3, 0, 0, 0};
        vecs[7] = '{1, 0, 255, 1, 1};
        vecs[8] = '{81, 9, 9, 0, 0};

        rst   = 1'b1;
        start = 1'b0;
        ia    = '0;
        ib    = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset ready", int'(ready), 1);
        chk("reset done", int'(done), 0);
        chk("reset dz", int'(dz), 0);
        chk("reset ot_q", int'(ot_q), 0);
        chk("reset ot_r", int'(ot_r), 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Table ops are issued back-to-back: each start lands in the previous DONE cycle.
        for (int i = 0; i < 9; i++) begin
            do_vec($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                   vecs[i].eq, vecs[i].er, vecs[i].ez);
        end
        chk("done is a single pulse", int'(done), 1);
        tick();
        chk("done drops after one cycle", int'(done), 0);
        chk("idle ready", int'(ready), 1);

        // Start pulse and operand changes during RUN are ignored.
        tick();
        ia = 8'd50;
        ib = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        ia = 8'd9;
        ib = 8'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 3;
        while (!done && lat < 30) begin
            tick();
            lat++;
        end
        chk("ignore-start latency", lat, 8);
        chk("ignore-start quotient", int'(ot_q), 16);
        chk("ignore-start remainder", int'(ot_r), 2);
        chk("ignore-start dz", int'(dz), 0);
        tick();

        // Asynchronous reset in the middle of a run.
        ia = 8'd200;
        ib = 8'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("abort ready", int'(ready), 1);
        chk("abort done", int'(done), 0);
        chk("abort ot_q", int'(ot_q), 0);
        chk("abort ot_r", int'(ot_r), 0);
        chk("abort dz", int'(dz), 0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done) seen++;
        end
        chk("no done after abort", seen, 0);
        do_vec("after abort", 200, 7, 28, 4, 0);

        // Randomized sweep against the arithmetic model and the division identity.
        for (int i = 0; i < 3000; i++) begin
            int a, b, q, r, z, l, re, he, eq, er;
            repeat ($urandom_range(0, 2)) tick();
            a = int'($urandom_range(0, 255));
            b = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(0, 255));
            eq = (b == 0) ? 255 : a / b;
            er = (b == 0) ? a : a % b;
            run_op(a, b, q, r, z, l, re, he);
            chk($sformatf("rand%0d %0d/%0d q", i, a, b), q, eq);
            chk($sformatf("rand%0d %0d/%0d r", i, a, b), r, er);
            chk($sformatf("rand%0d %0d/%0d dz", i, a, b), z, (b == 0) ? 1 : 0);
            chk($sformatf("rand%0d latency", i), l, (b == 0) ? 0 : 8);
            if (b != 0) begin
                chk($sformatf("rand%0d identity", i), q * b + r, a);
                chk($sformatf("rand%0d rem below divisor", i), (r < b) ? 1 : 0, 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
